// File: rtl/axi_readygen_pkg.sv
// Shared types and constants for the AXI4-Lite ready-shaping slave.
package axi_readygen_pkg;

  typedef enum logic [1:0] {
    RG_ALWAYS = 2'd0,
    RG_OSC    = 2'd1,
    RG_RANDOM = 2'd2,
    RG_DELAY  = 2'd3
  } ready_mode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One step of the 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi_ready_gen.sv
// Raw READY generator for one AXI channel: always-on, oscillating,
// pseudo-random or valid-delayed.  Output is forced low until the first
// clock after reset so every READY comes out of reset at 0.
module axi_ready_gen
  import axi_readygen_pkg::*;
#(
  parameter int          CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] low,
  input  logic [CNT_W-1:0] high,
  input  logic             valid,
  input  logic             hs,
  output logic             gen
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);

  ready_mode_e      w_mode;
  logic [CNT_W-1:0] w_high_m1;
  logic             w_dly_gen;
  logic             w_raw;

  logic             r_alive;
  logic             r_osc_run;
  logic             r_osc_gen;
  logic [CNT_W-1:0] r_osc_cnt;
  logic [15:0]      r_lfsr;
  logic [CNT_W-1:0] r_dly_cnt;

  assign w_mode    = ready_mode_e'(mode);
  // A high phase of 0 cycles is stretched to 1.
  assign w_high_m1 = (high == '0) ? '0 : (high - C_ONE);
  assign w_dly_gen = valid && (r_dly_cnt >= low);

  // Goes high one clock after reset release and stays there.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_alive <= 1'b0;
    else          r_alive <= 1'b1;
  end

  // OSC phase machine: r_osc_cnt holds cycles left in the current phase
  // after this one; config is read only when a new phase is loaded.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_osc_run <= 1'b0;
      r_osc_gen <= 1'b0;
      r_osc_cnt <= '0;
    end else if (w_mode != RG_OSC) begin
      r_osc_run <= 1'b0;
      r_osc_gen <= 1'b0;
      r_osc_cnt <= '0;
    end else if (!r_osc_run) begin
      // Current cycle is already the first low cycle.
      r_osc_run <= 1'b1;
      if (low <= C_ONE) begin
        r_osc_gen <= 1'b1;
        r_osc_cnt <= w_high_m1;
      end else begin
        r_osc_gen <= 1'b0;
        r_osc_cnt <= low - C_TWO;
      end
    end else if (r_osc_cnt != '0) begin
      r_osc_cnt <= r_osc_cnt - C_ONE;
    end else if (r_osc_gen && (low != '0)) begin
      r_osc_gen <= 1'b0;
      r_osc_cnt <= low - C_ONE;
    end else begin
      r_osc_gen <= 1'b1;
      r_osc_cnt <= w_high_m1;
    end
  end

  // LFSR free-runs every cycle regardless of mode.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_lfsr <= SEED;
    else          r_lfsr <= lfsr_next(r_lfsr);
  end

  // DELAY counter: cycles VALID has waited, saturating at LOW.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)               r_dly_cnt <= '0;
    else if (hs || !valid)      r_dly_cnt <= '0;
    else if (r_dly_cnt < low)   r_dly_cnt <= r_dly_cnt + C_ONE;
  end

  // Select the raw ready source for the configured policy.
  always_comb begin
    w_raw = 1'b0;
    case (w_mode)
      RG_ALWAYS: w_raw = 1'b1;
      RG_OSC:    w_raw = r_osc_gen;
      RG_RANDOM: w_raw = r_lfsr[0];
      RG_DELAY:  w_raw = w_dly_gen;
      default:   w_raw = 1'b0;
    endcase
  end

  assign gen = r_alive & w_raw;

endmodule

// File: rtl/axi_lite_slv_readygen.sv
// AXI4-Lite slave memory with per-channel READY shaping and a sticky
// protocol checker.  Handshake rule on every channel: a transfer happens on
// the rising edge where VALID and READY are both high; once VALID is raised
// the master must hold it and its payload stable until that edge.
module axi_lite_slv_readygen
  import axi_readygen_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 12,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [1:0]          AWMODE,
  input  logic [1:0]          WMODE,
  input  logic [1:0]          ARMODE,
  input  logic [CNT_W-1:0]    AWLOW,
  input  logic [CNT_W-1:0]    WLOW,
  input  logic [CNT_W-1:0]    ARLOW,
  input  logic [CNT_W-1:0]    AWHIGH,
  input  logic [CNT_W-1:0]    WHIGH,
  input  logic [CNT_W-1:0]    ARHIGH,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                ERROR
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int          AL     = $clog2(STRB_W);
  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [31:0] BYTES  = 32'(DEPTH * STRB_W);

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
    return a[AL +: IDX_W];
  endfunction

  logic w_aw_gen, w_w_gen, w_ar_gen;
  logic w_aw_hs, w_w_hs, w_ar_hs;
  logic w_commit, w_cm_ok;
  logic [ADDR_W-1:0] w_cm_addr;
  logic [DATA_W-1:0] w_cm_data;
  logic [STRB_W-1:0] w_cm_strb;
  logic w_viol;

  logic              r_aw_full, r_w_full;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [DATA_W-1:0] r_w_data;
  logic [STRB_W-1:0] r_w_strb;
  logic              r_bvalid, r_rvalid, r_error;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_awv_q, r_awr_q, r_wv_q, r_wr_q, r_arv_q, r_arr_q;
  logic [ADDR_W-1:0] r_awaddr_q, r_araddr_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic [STRB_W-1:0] r_wstrb_q;

  axi_ready_gen #(.CNT_W(CNT_W), .SEED(LFSR_SEED)) u_aw_gen (
    .ACLK(ACLK), .ARESETN(ARESETN), .mode(AWMODE), .low(AWLOW), .high(AWHIGH),
    .valid(AWVALID), .hs(w_aw_hs), .gen(w_aw_gen));

  axi_ready_gen #(.CNT_W(CNT_W), .SEED(LFSR_SEED ^ 16'h0001)) u_w_gen (
    .ACLK(ACLK), .ARESETN(ARESETN), .mode(WMODE), .low(WLOW), .high(WHIGH),
    .valid(WVALID), .hs(w_w_hs), .gen(w_w_gen));

  axi_ready_gen #(.CNT_W(CNT_W), .SEED(LFSR_SEED ^ 16'h0002)) u_ar_gen (
    .ACLK(ACLK), .ARESETN(ARESETN), .mode(ARMODE), .low(ARLOW), .high(ARHIGH),
    .valid(ARVALID), .hs(w_ar_hs), .gen(w_ar_gen));

  // AR stays open while the pending R beat is being taken this cycle.
  assign AWREADY = w_aw_gen & ~r_aw_full;
  assign WREADY  = w_w_gen & ~r_w_full;
  assign ARREADY = w_ar_gen & ~(r_rvalid & ~RREADY);
  assign w_aw_hs = AWVALID & AWREADY;
  assign w_w_hs  = WVALID & WREADY;
  assign w_ar_hs = ARVALID & ARREADY;

  // Commit takes each half from its slot or straight off the bus, so a
  // write whose AW and W arrive together answers on the next cycle.
  assign w_cm_addr = r_aw_full ? r_aw_addr : AWADDR;
  assign w_cm_data = r_w_full ? r_w_data : WDATA;
  assign w_cm_strb = r_w_full ? r_w_strb : WSTRB;
  assign w_commit  = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~r_bvalid;
  assign w_cm_ok   = f_in_range(w_cm_addr);

  // Holding slots for AW and W; emptied by the commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_commit) r_aw_full <= 1'b0;
      else if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= AWADDR;
      end
      if (w_commit) r_w_full <= 1'b0;
      else if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= WDATA;
        r_w_strb <= WSTRB;
      end
    end
  end

  // Write response register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_cm_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // Byte-enabled memory write; storage is deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_cm_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_cm_strb[b]) r_mem[f_idx(w_cm_addr)][b*8 +: 8] <= w_cm_data[b*8 +: 8];
      end
    end
  end

  // Read data register; a same-cycle commit is not visible (old data).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= f_in_range(ARADDR) ? r_mem[f_idx(ARADDR)] : '0;
      r_rresp  <= f_in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Previous-cycle view of master signals for the stability checker.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awv_q <= 1'b0; r_awr_q <= 1'b0; r_awaddr_q <= '0;
      r_wv_q  <= 1'b0; r_wr_q  <= 1'b0; r_wdata_q  <= '0; r_wstrb_q <= '0;
      r_arv_q <= 1'b0; r_arr_q <= 1'b0; r_araddr_q <= '0;
    end else begin
      r_awv_q <= AWVALID; r_awr_q <= AWREADY; r_awaddr_q <= AWADDR;
      r_wv_q  <= WVALID;  r_wr_q  <= WREADY;  r_wdata_q  <= WDATA; r_wstrb_q <= WSTRB;
      r_arv_q <= ARVALID; r_arr_q <= ARREADY; r_araddr_q <= ARADDR;
    end
  end

  // A channel left pending last cycle must still be valid with equal payload.
  assign w_viol =
      (r_awv_q & ~r_awr_q & (~AWVALID | (AWADDR != r_awaddr_q))) |
      (r_wv_q  & ~r_wr_q  & (~WVALID | (WDATA != r_wdata_q) | (WSTRB != r_wstrb_q))) |
      (r_arv_q & ~r_arr_q & (~ARVALID | (ARADDR != r_araddr_q)));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_error <= 1'b0;
    else          r_error <= r_error | w_viol;
  end

  assign BVALID = r_bvalid;
  assign BRESP  = r_bresp;
  assign RVALID = r_rvalid;
  assign RDATA  = r_rdata;
  assign RRESP  = r_rresp;
  assign ERROR  = r_error;

endmodule

// File: tb/tb_axi_lite_slv_readygen.sv
// Directed bench for axi_lite_slv_readygen (32-bit data, 256 words).
module tb_axi_lite_slv_readygen;
  import axi_readygen_pkg::*;

  logic        ACLK, ARESETN;
  logic [1:0]  AWMODE, WMODE, ARMODE;
  logic [7:0]  AWLOW, WLOW, ARLOW, AWHIGH, WHIGH, ARHIGH;
  logic [11:0] AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, ERROR;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [8];
  logic [31:0] rd;
  logic [1:0]  rsp;

  axi_lite_slv_readygen dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWMODE(AWMODE), .WMODE(WMODE), .ARMODE(ARMODE),
    .AWLOW(AWLOW), .WLOW(WLOW), .ARLOW(ARLOW),
    .AWHIGH(AWHIGH), .WHIGH(WHIGH), .ARHIGH(ARHIGH),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .ERROR(ERROR));

  // Clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge (drive point).
  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic idle_inputs();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b0; RREADY = 1'b0;
  endtask

  task automatic reset_dut();
    ARESETN = 1'b0;
    idle_inputs();
    step(); step();
    ARESETN = 1'b1;
    step(); step();
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    int n;
    logic aw_ok, w_ok;
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 50) begin
      #1;
      if (AWVALID && AWREADY) aw_ok = 1'b1;
      if (WVALID && WREADY) w_ok = 1'b1;
      step(); n++;
      if (aw_ok) AWVALID = 1'b0;
      if (w_ok) WVALID = 1'b0;
    end
    chk("wr_accept", {aw_ok, w_ok}, 2'b11);
    n = 0;
    #1;
    while (!BVALID && n < 20) begin step(); #1; n++; end
    chk("wr_bvalid", BVALID, 1'b1);
    resp = BRESP;
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic ok;
    ARADDR = a; ARVALID = 1'b1; ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      #1;
      ok = ARREADY;
      step(); n++;
    end
    ARVALID = 1'b0;
    chk("rd_accept", ok, 1'b1);
    n = 0;
    #1;
    while (!RVALID && n < 20) begin step(); #1; n++; end
    chk("rd_rvalid", RVALID, 1'b1);
    d = RDATA;
    resp = RRESP;
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
  endtask

  initial begin
    int acc, cyc, hi, nb;
    ARESETN = 1'b0;
    AWMODE = RG_ALWAYS; WMODE = RG_ALWAYS; ARMODE = RG_ALWAYS;
    AWLOW = '0; WLOW = '0; ARLOW = '0; AWHIGH = '0; WHIGH = '0; ARHIGH = '0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
    idle_inputs();
    step(); step(); step();

    // Reset state
    #1;
    chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0); chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rdata", RDATA, 0);
    chk("rst_bresp", BRESP, 0);     chk("rst_rresp", RRESP, 0);
    chk("rst_error", ERROR, 0);
    step();
    ARESETN = 1'b1;
    step(); step();

    // 1: ALWAYS, write then read 0x010
    AWADDR = 12'h010; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    #1;
    chk("t1_awready_c0", AWREADY, 1); chk("t1_wready_c0", WREADY, 1);
    chk("t1_bvalid_c0", BVALID, 0);
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("t1_bvalid", BVALID, 1); chk("t1_bresp", BRESP, RESP_OKAY);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    #1;
    chk("t1_bvalid_clr", BVALID, 0);
    ARADDR = 12'h010; ARVALID = 1'b1;
    #1;
    chk("t1_arready", ARREADY, 1);
    step();
    ARVALID = 1'b0;
    #1;
    chk("t1_rvalid", RVALID, 1); chk("t1_rdata", RDATA, 32'hDEADBEEF);
    chk("t1_rresp", RRESP, RESP_OKAY);
    step();
    #1;
    chk("t1_rvalid_hold", RVALID, 1); chk("t1_rdata_hold", RDATA, 32'hDEADBEEF);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    #1;
    chk("t1_rvalid_clr", RVALID, 0);
    step();

    // 4: W leads AW by 3 cycles, partial strobes
    do_write(12'h020, 32'hFFFFFFFF, 4'hF, rsp);
    chk("t4_pre_bresp", rsp, RESP_OKAY);
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
    #1;
    chk("t4_wready", WREADY, 1);
    step();
    WVALID = 1'b0;
    #1;
    chk("t4_wready_slot_full", WREADY, 0); chk("t4_no_b_early", BVALID, 0);
    step(); step();
    AWADDR = 12'h020; AWVALID = 1'b1;
    #1;
    chk("t4_awready", AWREADY, 1);
    step();
    AWVALID = 1'b0;
    #1;
    chk("t4_bvalid", BVALID, 1); chk("t4_bresp", BRESP, RESP_OKAY);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    #1;
    chk("t4_bvalid_clr", BVALID, 0);
    step();
    #1;
    chk("t4_single_b", BVALID, 0);
    step();
    do_read(12'h020, rd, rsp);
    chk("t4_merged", rd, 32'hFF22FF44);

    // 5: out-of-range write and read
    do_write(12'h3FC, 32'hCAFEF00D, 4'hF, rsp);
    chk("t5_inrange_bresp", rsp, RESP_OKAY);
    do_write(12'hFFC, 32'h12345678, 4'hF, rsp);
    chk("t5_oor_bresp", rsp, RESP_SLVERR);
    do_read(12'hFFC, rd, rsp);
    chk("t5_oor_rdata", rd, 0); chk("t5_oor_rresp", rsp, RESP_SLVERR);
    do_read(12'h3FC, rd, rsp);
    chk("t5_mem_unchanged", rd, 32'hCAFEF00D); chk("t5_rresp", rsp, RESP_OKAY);

    // 3: RANDOM AR with scoreboard
    for (int k = 0; k < 8; k++) begin
      model[k] = 32'h10000000 + 32'(k) * 32'h01010101;
      do_write(12'h100 + 12'(4 * k), model[k], 4'hF, rsp);
    end
    ARMODE = RG_RANDOM;
    acc = 0; cyc = 0; hi = 0;
    RREADY = 1'b1;
    ARADDR = 12'h100; ARVALID = 1'b1;
    while ((acc < 100 || exp_q.size() > 0) && cyc < 1000) begin
      #1;
      if (RVALID) begin
        if (exp_q.size() == 0) chk("t3_unexpected_r", RVALID, 0);
        else chk("t3_rdata", RDATA, exp_q.pop_front());
      end
      if (cyc < 100 && ARREADY) hi++;
      if (ARVALID && ARREADY) begin
        exp_q.push_back(model[acc % 8]);
        acc++;
      end
      step(); cyc++;
      if (acc >= 100) ARVALID = 1'b0;
      else ARADDR = 12'h100 + 12'(4 * (acc % 8));
    end
    RREADY = 1'b0;
    chk("t3_reads_done", acc, 100);
    chk("t3_queue_drained", exp_q.size(), 0);
    chk("t3_ready_ratio_ok", (hi >= 35 && hi <= 65), 1);
    chk("t3_error", ERROR, 0);
    ARMODE = RG_ALWAYS;

    // 2: OSC W ready, LOW=5 HIGH=1, counted from reset release
    WMODE = RG_OSC; WLOW = 8'd5; WHIGH = 8'd1;
    ARESETN = 1'b0;
    idle_inputs();
    step(); step();
    AWADDR = 12'h040; AWVALID = 1'b1;
    WDATA = 32'h0BADCAFE; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b1;
    ARESETN = 1'b1;
    #1;
    chk("t2_wready_c0", WREADY, 0);
    nb = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      #1;
      chk($sformatf("t2_wready_c%0d", i), WREADY, (i % 6 == 5) ? 1 : 0);
      if (BVALID) nb++;
    end
    chk("t2_b_count", nb, 2);
    chk("t2_error", ERROR, 0);
    WMODE = RG_ALWAYS; WLOW = '0; WHIGH = '0;
    step();
    reset_dut();

    // 6a: DELAY on AW with LOW=2
    AWMODE = RG_DELAY; AWLOW = 8'd2;
    AWADDR = 12'h050; AWVALID = 1'b1;
    WDATA = 32'h55AA55AA; WSTRB = 4'hF; WVALID = 1'b1;
    #1;
    chk("t6_dly_c0", AWREADY, 0); chk("t6_w_c0", WREADY, 1);
    step();
    WVALID = 1'b0;
    #1;
    chk("t6_dly_c1", AWREADY, 0);
    step();
    #1;
    chk("t6_dly_c2", AWREADY, 1);
    step();
    AWVALID = 1'b0;
    #1;
    chk("t6_dly_fall", AWREADY, 0); chk("t6_dly_bvalid", BVALID, 1);
    chk("t6_dly_error", ERROR, 0);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;

    // 6b: AWVALID dropped before AWREADY
    AWLOW = 8'd5;
    AWADDR = 12'h060; AWVALID = 1'b1;
    #1;
    chk("t6_drop_ready0", AWREADY, 0);
    step();
    #1;
    chk("t6_drop_ready1", AWREADY, 0);
    step();
    AWVALID = 1'b0;
    #1;
    chk("t6_error_pre", ERROR, 0);
    step();
    #1;
    chk("t6_error_set", ERROR, 1);
    step(); step();
    #1;
    chk("t6_error_sticky", ERROR, 1);

    // 6c: reset while BVALID=1
    AWMODE = RG_ALWAYS; AWLOW = '0;
    step();
    AWADDR = 12'h070; AWVALID = 1'b1; WDATA = 32'h01020304; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    #1;
    chk("t6_bvalid_before_rst", BVALID, 1); chk("t6_error_before_rst", ERROR, 1);
    ARESETN = 1'b0;
    #1;
    chk("t6_rst_bvalid", BVALID, 0); chk("t6_rst_error", ERROR, 0);
    chk("t6_rst_awready", AWREADY, 0);
    step();
    ARESETN = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
